// File: rtl/mor1kx_icache_refill.sv
// Instruction-cache line refill engine: fetches one cache line as a critical-word-first
// wrapping burst on the instruction bus and streams each returned beat into the cache.
module mor1kx_icache_refill #(
   parameter int OPTION_OPERAND_WIDTH      = 32,
   parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            refill_req_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
   output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
   output logic [31:0]                     wrdat_o,
   output logic                            we_o,
   output logic                            err_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
   output logic                            ibus_req_o,
   output logic                            ibus_burst_o,
   input  logic                            ibus_ack_i,
   input  logic                            ibus_err_i,
   input  logic [31:0]                     ibus_dat_i
);

   localparam int AW = OPTION_OPERAND_WIDTH;
   localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
   localparam int CW = BW - 2;

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          abort_q, abort_d;
   logic          req_q, req_d;
   logic          burst_q, burst_d;

   logic          in_burst;
   logic          aborting;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] off_inc;
   logic [AW-1:0] adr_inc;

   assign in_burst = (state_q == BURST);
   // A cache abort may be seen only in the ack cycle itself, so the live level is OR-ed in.
   assign aborting = abort_q | ~refill_req_i;
   assign cnt_inc  = cnt_q + CW'(1);
   assign off_inc  = adr_q[BW-1:2] + CW'(1);
   assign adr_inc  = {adr_q[AW-1:BW], off_inc, 2'b00};

   assign ibus_adr_o   = adr_q;
   assign ibus_req_o   = req_q;
   assign ibus_burst_o = burst_q;
   assign wradr_o      = adr_q;
   assign wrdat_o      = ibus_dat_i;
   assign we_o         = in_burst & ibus_ack_i & ~ibus_err_i & ~aborting;
   assign err_o        = in_burst & ibus_err_i;

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      req_d   = req_q;
      burst_d = burst_q;
      unique case (state_q)
         IDLE: begin
            if (refill_req_i) begin
               adr_d   = {refill_adr_i[AW-1:2], 2'b00};
               cnt_d   = '0;
               abort_d = 1'b0;
               req_d   = 1'b1;
               burst_d = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            if (ibus_err_i) begin
               req_d   = 1'b0;
               burst_d = 1'b0;
               state_d = IDLE;
            end else if (ibus_ack_i) begin
               adr_d = adr_inc;
               cnt_d = cnt_inc;
               if (aborting) begin
                  req_d   = 1'b0;
                  burst_d = 1'b0;
                  state_d = IDLE;
               end else if (&cnt_q) begin
                  req_d   = 1'b0;
                  burst_d = 1'b0;
                  state_d = DONE;
               end else begin
                  burst_d = ~(&cnt_inc);
               end
            end else begin
               abort_d = aborting;
            end
         end
         DONE: begin
            // Cache still holds refill_req_i this cycle; going straight to IDLE avoids a re-fetch.
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            burst_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         req_q   <= 1'b0;
         burst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         req_q   <= req_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: tb/tb_mor1kx_icache_refill.sv
// Directed bench for mor1kx_icache_refill: 8-beat and 4-beat line variants on a shared bus model.
module tb_mor1kx_icache_refill;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req5 = 1'b0, req4 = 1'b0;
   logic [31:0] adr_in = '0;
   logic        ack = 1'b0, err = 1'b0;
   logic [31:0] dat = '0;

   logic [31:0] wradr5, wrdat5, iadr5, wradr4, wrdat4, iadr4;
   logic        we5, err5, ireq5, iburst5, we4, err4, ireq4, iburst4;

   logic        sel4 = 1'b0;
   logic [31:0] o_wradr, o_wrdat, o_iadr;
   logic        o_we, o_err, o_ireq, o_iburst;

   int n_cmp = 0;
   int n_err = 0;
   int we_cnt = 0;

   always #5 clk = ~clk;

   mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .refill_req_i(req5), .refill_adr_i(adr_in),
      .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5), .err_o(err5),
      .ibus_adr_o(iadr5), .ibus_req_o(ireq5), .ibus_burst_o(iburst5),
      .ibus_ack_i(ack), .ibus_err_i(err), .ibus_dat_i(dat));

   mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .refill_req_i(req4), .refill_adr_i(adr_in),
      .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .err_o(err4),
      .ibus_adr_o(iadr4), .ibus_req_o(ireq4), .ibus_burst_o(iburst4),
      .ibus_ack_i(ack), .ibus_err_i(err), .ibus_dat_i(dat));

   always_comb begin
      o_wradr  = sel4 ? wradr4  : wradr5;
      o_wrdat  = sel4 ? wrdat4  : wrdat5;
      o_iadr   = sel4 ? iadr4   : iadr5;
      o_we     = sel4 ? we4     : we5;
      o_err    = sel4 ? err4    : err5;
      o_ireq   = sel4 ? ireq4   : ireq5;
      o_iburst = sel4 ? iburst4 : iburst5;
   end

   always @(negedge clk) if (o_we) we_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v);
      if (sel4) req4 = v;
      else      req5 = v;
   endtask

   // One refill: waits idle cycles before each ack; err_beat / abort_beat = -1 to disable.
   task automatic do_refill(input logic [31:0] start, input int waits,
                            input int err_beat, input int abort_beat);
      logic [31:0] exp, mask;
      int beats, exp_we;
      beats  = sel4 ? 4 : 8;
      mask   = sel4 ? 32'hF : 32'h1F;
      exp    = start & ~32'h3;
      exp_we = beats;
      step();
      we_cnt = 0;
      adr_in = start;
      set_req(1'b1);
      #1 chk("idle_no_req", {31'b0, o_ireq}, 32'd0);
      for (int b = 0; b < beats; b++) begin
         for (int w = 0; w < waits; w++) begin
            step();
            ack = 1'b0;
            err = 1'b0;
            if (b == abort_beat && w == 0) set_req(1'b0);
            #1;
            chk("wait_req", {31'b0, o_ireq}, 32'd1);
            chk("wait_adr_stable", o_iadr, exp);
            chk("wait_we", {31'b0, o_we}, 32'd0);
         end
         step();
         if (b == abort_beat) set_req(1'b0);
         ack = 1'b1;
         err = (b == err_beat);
         dat = exp ^ 32'hDEAD_0000;
         #1;
         chk("beat_req", {31'b0, o_ireq}, 32'd1);
         chk("beat_adr", o_iadr, exp);
         chk("beat_wradr", o_wradr, exp);
         chk("beat_burst", {31'b0, o_iburst}, {31'b0, b != beats - 1});
         chk("beat_we", {31'b0, o_we}, {31'b0, b != err_beat && b != abort_beat});
         chk("beat_err", {31'b0, o_err}, {31'b0, b == err_beat});
         if (b != err_beat && b != abort_beat) chk("beat_wrdat", o_wrdat, exp ^ 32'hDEAD_0000);
         if (b == err_beat || b == abort_beat) begin
            exp_we = b;
            step();
            ack = 1'b0;
            err = 1'b0;
            set_req(1'b0);
            #1;
            chk("end_req", {31'b0, o_ireq}, 32'd0);
            chk("end_err_pulse", {31'b0, o_err}, 32'd0);
            step();
            chk("no_restart", {31'b0, o_ireq}, 32'd0);
            chk("we_count", we_cnt, exp_we);
            return;
         end
         exp = (exp & ~mask) | ((exp + 32'd4) & mask);
      end
      // DONE: cache still requests, stray ack must be ignored.
      step();
      ack = 1'b1;
      #1;
      chk("done_req", {31'b0, o_ireq}, 32'd0);
      chk("done_we", {31'b0, o_we}, 32'd0);
      chk("done_burst", {31'b0, o_iburst}, 32'd0);
      step();
      ack = 1'b0;
      set_req(1'b0);
      #1 chk("idle_req", {31'b0, o_ireq}, 32'd0);
      step();
      chk("no_restart", {31'b0, o_ireq}, 32'd0);
      chk("we_count", we_cnt, exp_we);
   endtask

   initial begin
      #12;
      chk("rst_req5", {31'b0, ireq5}, 32'd0);
      chk("rst_burst5", {31'b0, iburst5}, 32'd0);
      chk("rst_we5", {31'b0, we5}, 32'd0);
      chk("rst_err5", {31'b0, err5}, 32'd0);
      chk("rst_wradr5", wradr5, 32'd0);
      chk("rst_req4", {31'b0, ireq4}, 32'd0);
      #10 rst_n = 1'b1;

      do_refill(32'h0000_1000, 0, -1, -1);
      do_refill(32'h0000_2014, 0, -1, -1);
      do_refill(32'h0000_1003, 3, -1, -1);
      do_refill(32'h0000_3000, 0, 2, -1);
      do_refill(32'h0000_5008, 1, -1, 1);
      sel4 = 1'b1;
      do_refill(32'h0000_040C, 0, -1, -1);
      do_refill(32'h0000_0424, 0, 3, -1);
      sel4 = 1'b0;

      // Asynchronous reset in the middle of a burst.
      step();
      adr_in = 32'h0000_7000;
      req5 = 1'b1;
      step();
      ack = 1'b1;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, ireq5}, 32'd0);
      chk("mid_rst_burst", {31'b0, iburst5}, 32'd0);
      chk("mid_rst_we", {31'b0, we5}, 32'd0);
      chk("mid_rst_wradr", wradr5, 32'd0);
      ack = 1'b0;
      req5 = 1'b0;
      #3 rst_n = 1'b1;
      step();
      chk("post_rst_req", {31'b0, ireq5}, 32'd0);
      step();
      chk("post_rst_req2", {31'b0, ireq5}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
